// File: rtl/rank_filter_nxn_pkg.sv
// rank_filter_pkg: shared sizing helpers and pixel type for the rank-order filter family
package rank_filter_pkg;
   localparam int PIX_W = 8;
   typedef logic [PIX_W-1:0] pixel_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int N_OF(input int win);
      return win * win;
   endfunction

   function automatic int MEDIAN_RANK(input int win);
      return (win * win - 1) / 2;
   endfunction
endpackage

// File: rtl/rank_filter_nxn_core.sv
// rank_select_core: picks the element of a given order statistic from N pixels, 3-cycle latency
module rank_select_core
   import rank_filter_pkg::*;
#(
   parameter int N = 25,
   parameter int DATA_W = 8,
   localparam int RW = clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid,
   input  logic [N*DATA_W-1:0] pix,
   input  logic [RW-1:0]       rank,
   output logic [DATA_W-1:0]   sel,
   output logic                sel_valid
);
   localparam int P = N * (N - 1) / 2;

   function automatic int pidx(input int a, input int b);
      return a * N - a * (a + 1) / 2 + b - a - 1;
   endfunction

   logic [P-1:0]        cmp_d, cmp1;
   logic [N*DATA_W-1:0] pix1, pix2;
   logic [RW-1:0]       rank1, rank2;
   logic [N*RW-1:0]     cnt_d, cnt2;
   logic [DATA_W-1:0]   sel_d;
   logic                v1, v2;

   // one bit per pair i<j: set when x_j < x_i; ties resolve toward the lower index
   for (genvar i = 0; i < N; i++) begin : g_i
      for (genvar j = i + 1; j < N; j++) begin : g_j
         assign cmp_d[pidx(i, j)] = pix[j*DATA_W +: DATA_W] < pix[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (j < i) cnt_d[i*RW +: RW] += RW'(!cmp1[pidx(j, i)]);
            else if (j > i) cnt_d[i*RW +: RW] += RW'(cmp1[pidx(i, j)]);
   end

   always_comb begin
      sel_d = '0;
      for (int i = 0; i < N; i++)
         sel_d |= (cnt2[i*RW +: RW] == rank2) ? pix2[i*DATA_W +: DATA_W] : '0;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         sel_valid <= 1'b0;
         cmp1 <= '0;
         pix1 <= '0;
         pix2 <= '0;
         rank1 <= '0;
         rank2 <= '0;
         cnt2 <= '0;
         sel <= '0;
      end else begin
         v1 <= valid;
         cmp1 <= cmp_d;
         pix1 <= pix;
         rank1 <= rank;
         v2 <= v1;
         cnt2 <= cnt_d;
         pix2 <= pix1;
         rank2 <= rank1;
         sel_valid <= v2;
         if (v2) sel <= sel_d;
      end
endmodule

// File: rtl/rank_filter_nxn.sv
// rank_filter_nxn: sliding WIN x WIN rank-order filter over column-fed pixel streams
module rank_filter_nxn
   import rank_filter_pkg::*;
#(
   parameter int WIN = 5,
   parameter int DATA_W = 8,
   parameter int ROWS = 7,
   parameter int COLS = 7,
   localparam int N = N_OF(WIN),
   localparam int RW = clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  done_i,
   input  logic [WIN*DATA_W-1:0] col_i,
   input  logic [RW-1:0]         rank_i,
   output logic [DATA_W-1:0]     median_o,
   output logic                  done_o,
   output logic                  frame_done_o
);
   localparam int CW = clog2(COLS);
   localparam int RCW = clog2(ROWS);

   logic [WIN*DATA_W-1:0] slot [WIN];
   logic [N*DATA_W-1:0]   win_flat;
   logic [CW-1:0]         col_cnt;
   logic [RCW-1:0]        row_cnt;
   logic [RW-1:0]         rank_q, rank0;
   logic [2:0]            last_d;
   logic                  v0, last0;
   logic                  last_col, last_row, complete, frame_start;

   assign last_col = col_cnt == CW'(COLS - 1);
   assign last_row = row_cnt == RCW'(ROWS - WIN);
   assign complete = done_i && col_cnt >= CW'(WIN - 1);
   assign frame_start = done_i && col_cnt == '0 && row_cnt == '0;
   assign frame_done_o = last_d[2];

   // row-major flattening: element r*WIN+c is row r of column slot c
   for (genvar r = 0; r < WIN; r++) begin : g_r
      for (genvar c = 0; c < WIN; c++) begin : g_c
         assign win_flat[(r*WIN+c)*DATA_W +: DATA_W] = slot[c][r*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         for (int i = 0; i < WIN; i++) slot[i] <= '0;
      end else if (done_i) begin
         for (int i = 0; i < WIN - 1; i++) slot[i] <= slot[i+1];
         slot[WIN-1] <= col_i;
      end

   // rank travels with each window so back-to-back frames keep their own rank
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
         rank_q <= RW'(MEDIAN_RANK(WIN));
         rank0 <= '0;
         v0 <= 1'b0;
         last0 <= 1'b0;
         last_d <= '0;
      end else begin
         if (done_i) col_cnt <= last_col ? '0 : col_cnt + 1'b1;
         if (done_i && last_col) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
         if (frame_start) rank_q <= (rank_i > RW'(N - 1)) ? RW'(N - 1) : rank_i;
         if (complete) rank0 <= rank_q;
         v0 <= complete;
         last0 <= complete && last_col && last_row;
         last_d <= {last_d[1:0], last0};
      end

   rank_select_core #(.N(N), .DATA_W(DATA_W)) u_core (
      .clk(clk),
      .rst(rst),
      .valid(v0),
      .pix(win_flat),
      .rank(rank0),
      .sel(median_o),
      .sel_valid(done_o)
   );
endmodule
